pirdsp_simd_mac: RTL and testbench
==================================

// Module: pirdsp_simd_mac
// PURPOSE
//  Pipelined, parametrised SIMD multiplier for the PIR-DSP mapping flow. It is the next
//  generation of the fixed two-lane 9x9 sum-of-products cell.
//  - Splits A/B into LANES sub-words of LANE_W bits and multiplies lane-by-lane.
//  - Per beat it returns either the sum of lane products, the packed lane products, or a
//    running accumulation over a burst.
//  - Sits between operand staging and result write-back; valid/ready on both sides.
// PARAMETERS
//  LANE_W   9   bits per lane operand
//  LANES    2   number of lanes (>=1)
//  OUT_W    LANES*2*LANE_W (derived localparam, not overridable) result width
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        block can accept a beat this cycle
//  in_a       in   LANES*LANE_W  lane i = in_a[i*LANE_W +: LANE_W]
//  in_b       in   LANES*LANE_W  lane i = in_b[i*LANE_W +: LANE_W]
//  in_signed  in   1        1: lanes are two's complement; 0: unsigned
//  in_mode    in   2        0=SUM, 1=PACKED, 2=ACC, 3=reserved (treated as SUM)
//  in_last    in   1        ACC mode only: final beat of burst
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_y      out  OUT_W    result
// BEHAVIOUR
//  - Reset: out_valid=0, out_y=0, all stage valids=0, accumulator=0; in_ready=1 the cycle after.
//  - Pipeline: S1 operand/control regs -> S2 lane products -> S3 reduce/accumulate/out regs.
//  - Latency: beat accepted at edge N appears at out_y at edge N+3 when never stalled.
//  - Throughput: 1 beat/cycle.
//  - Stall: adv = out_ready | ~out_valid; in_ready = adv.
//    - All stages advance only when adv=1. Bubbles are not collapsed.
//    - out_y is held stable while out_valid & ~out_ready.
//  - Handshake: beat taken iff in_valid & in_ready. Result consumed iff out_valid & out_ready.
//    - in_ready does not depend combinationally on in_valid.
//  - Mode, signed and last travel with the beat, so mixing modes beat-to-beat is legal.
//  - Lane product p_i:
//    - in_signed=1: signed(a_i)*signed(b_i), sign-extended.
//    - in_signed=0: unsigned product, zero-extended.
//    - Width 2*LANE_W.
//  - SUM: out_y = sum of p_i, each extended to OUT_W; wraps modulo 2^OUT_W.
//  - PACKED: out_y[i*2*LANE_W +: 2*LANE_W] = p_i.
//  - ACC:
//    - acc_next = acc + sum(p_i) mod 2^OUT_W; sum(p_i) is formed as in SUM, signedness per beat.
//    - Non-last beat updates acc and emits no output (no out_valid).
//    - Last beat: out_y = acc_next, out_valid=1, acc <= 0 in the same edge.
//    - A single-beat burst (first beat has last=1) returns its own sum.
//  - Non-ACC beats arriving mid-burst pass through normally and leave acc untouched.
//  - in_last is ignored outside ACC.
//  - rst mid-operation: all in-flight beats and any partial acc are discarded; no output follows.
// TESTING (LANE_W=9, LANES=2)
//  1. SUM signed: a={9'h1FF,9'd3}, b={9'd5,9'd4}
//     -> out_y=36'd7, out_valid exactly 3 cycles after accept.
//  2. Same operands, signed=0 -> out_y=36'd2567.
//     Same operands, signed=1, PACKED -> out_y=36'hFFFEC000C.
//  3. ACC: 3 beats of case-1 operands, last on beat 3
//     -> exactly one result, out_y=36'd21; next burst starts from 0.
//  4. Backpressure: stream 6 SUM beats, hold out_ready=0 for 5 cycles
//     -> out_y stable, in_ready=0 once the pipe is full, all 6 results in order, none lost.
//  5. rst asserted after 2 beats of an ACC burst
//     -> no out_valid. A following 1-beat ACC burst (case-1 operands, last=1) -> 36'd7.
//  6. Back-to-back mixed modes SUM, PACKED, ACC(last), with out_ready=1
//     -> 3 results on consecutive cycles, each matching its own mode.

Source files
------------

// File: rtl/pirdsp_simd_mac.sv
// rtl/pirdsp_simd_mac.sv - pipelined SIMD lane multiplier with sum/packed/accumulate result modes
module pirdsp_simd_mac #(
  parameter int LANE_W = 9,
  parameter int LANES  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*LANE_W-1:0]     in_a,
  input  logic [LANES*LANE_W-1:0]     in_b,
  input  logic                        in_signed,
  input  logic [1:0]                  in_mode,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*2*LANE_W-1:0]   out_y
);
  localparam int IN_W  = LANES * LANE_W;
  localparam int P_W   = 2 * LANE_W;
  localparam int OUT_W = LANES * P_W;

  localparam logic [1:0] MODE_PACKED = 2'd1;
  localparam logic [1:0] MODE_ACC    = 2'd2;

  logic adv;

  logic            s1_valid, s1_signed, s1_last;
  logic [1:0]      s1_mode;
  logic [IN_W-1:0] s1_a, s1_b;

  logic             s2_valid, s2_signed, s2_last;
  logic [1:0]       s2_mode;
  logic [OUT_W-1:0] s2_prod;

  logic             s3_valid, s3_last;
  logic [1:0]       s3_mode;
  logic [OUT_W-1:0] s3_prod, s3_sum;

  logic [OUT_W-1:0] prod, sum, acc, acc_next, p_ext;
  logic [P_W-1:0]   ext_a, ext_b;

  // One global advance: every stage moves together, so bubbles stay in place.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_signed <= 1'b0;
      s1_last   <= 1'b0;
      s1_mode   <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_signed <= in_signed;
      s1_last   <= in_last;
      s1_mode   <= in_mode;
      s1_a      <= in_a;
      s1_b      <= in_b;
    end
  end

  // Extending both operands to 2*LANE_W makes one truncated multiply serve signed and unsigned.
  always_comb begin
    prod  = '0;
    ext_a = '0;
    ext_b = '0;
    for (int i = 0; i < LANES; i++) begin
      ext_a = {{LANE_W{s1_signed & s1_a[i*LANE_W+LANE_W-1]}}, s1_a[i*LANE_W +: LANE_W]};
      ext_b = {{LANE_W{s1_signed & s1_b[i*LANE_W+LANE_W-1]}}, s1_b[i*LANE_W +: LANE_W]};
      prod[i*P_W +: P_W] = ext_a * ext_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_signed <= 1'b0;
      s2_last   <= 1'b0;
      s2_mode   <= '0;
      s2_prod   <= '0;
    end else if (adv) begin
      s2_valid  <= s1_valid;
      s2_signed <= s1_signed;
      s2_last   <= s1_last;
      s2_mode   <= s1_mode;
      s2_prod   <= prod;
    end
  end

  always_comb begin
    sum   = '0;
    p_ext = '0;
    for (int i = 0; i < LANES; i++) begin
      p_ext          = {OUT_W{s2_signed & s2_prod[i*P_W+P_W-1]}};
      p_ext[P_W-1:0] = s2_prod[i*P_W +: P_W];
      sum            = sum + p_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
      s3_mode  <= '0;
      s3_prod  <= '0;
      s3_sum   <= '0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      s3_last  <= s2_last;
      s3_mode  <= s2_mode;
      s3_prod  <= s2_prod;
      s3_sum   <= sum;
    end
  end

  assign acc_next = acc + s3_sum;

  // Only the closing beat of an ACC burst produces a result; earlier beats just fold into acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      acc       <= '0;
    end else if (adv) begin
      out_valid <= s3_valid & ((s3_mode != MODE_ACC) | s3_last);
      if (s3_valid) begin
        if (s3_mode == MODE_ACC) begin
          if (s3_last) begin
            out_y <= acc_next;
            acc   <= '0;
          end else begin
            acc   <= acc_next;
          end
        end else if (s3_mode == MODE_PACKED) begin
          out_y <= s3_prod;
        end else begin
          out_y <= s3_sum;
        end
      end
    end
  end
endmodule

// File: tb/tb_pirdsp_simd_mac.sv
// tb/tb_pirdsp_simd_mac.sv - directed self-checking bench for pirdsp_simd_mac (LANE_W=9, LANES=2)
module tb_pirdsp_simd_mac;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_signed, in_last, out_valid, out_ready;
  logic [17:0] in_a, in_b;
  logic [1:0]  in_mode;
  logic [35:0] out_y;

  localparam logic [17:0] A1 = {9'h1FF, 9'd3};
  localparam logic [17:0] B1 = {9'd5, 9'd4};

  int          checks = 0;
  int          errors = 0;
  int          nres   = 0;
  int          npush  = 0;
  logic [35:0] expq[$];
  logic [35:0] exp_val;
  logic [35:0] held;

  always #5 clk = ~clk;

  pirdsp_simd_mac #(.LANE_W(9), .LANES(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      nres++;
      if (expq.size() == 0) begin
        check("unexpected_result", 64'(expq.size()), 64'd1);
      end else begin
        exp_val = expq.pop_front();
        check("result", 64'(out_y), 64'(exp_val));
      end
    end
  end

  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic s,
                      input logic [1:0] m, input logic l, input logic has, input logic [35:0] e);
    int n = 0;
    in_a = a; in_b = b; in_signed = s; in_mode = m; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    if (has) begin
      expq.push_back(e);
      npush++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(expq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    in_mode = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // signed SUM and exact three-cycle latency
    send(A1, B1, 1'b1, 2'd0, 1'b0, 1'b1, 36'd7);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("latency_early", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    check("latency_on_time", 64'(out_valid), 64'd1);
    drain();

    // unsigned/packed/boundary operands, reserved mode, last ignored outside ACC
    send(A1, B1, 1'b0, 2'd0, 1'b0, 1'b1, 36'd2567);
    send(A1, B1, 1'b1, 2'd1, 1'b0, 1'b1, 36'hFFFEC000C);
    send({9'h100, 9'h100}, {9'h100, 9'h100}, 1'b1, 2'd0, 1'b0, 1'b1, 36'd131072);
    send({9'h100, 9'h100}, {9'h100, 9'h100}, 1'b1, 2'd1, 1'b0, 1'b1, 36'h400010000);
    send({9'h1FF, 9'h1FF}, {9'h1FF, 9'h1FF}, 1'b0, 2'd0, 1'b0, 1'b1, 36'd522242);
    send({9'h1FF, 9'h1FF}, {9'd1, 9'd1}, 1'b1, 2'd0, 1'b0, 1'b1, 36'hFFFFFFFFE);
    send(A1, B1, 1'b1, 2'd3, 1'b0, 1'b1, 36'd7);
    send(A1, B1, 1'b1, 2'd0, 1'b1, 1'b1, 36'd7);
    drain();

    // ACC bursts, single-beat burst, non-ACC beat inside a burst
    send(A1, B1, 1'b1, 2'd2, 1'b0, 1'b0, 36'd0);
    send(A1, B1, 1'b1, 2'd2, 1'b0, 1'b0, 36'd0);
    send(A1, B1, 1'b1, 2'd2, 1'b1, 1'b1, 36'd21);
    send(A1, B1, 1'b1, 2'd2, 1'b1, 1'b1, 36'd7);
    send(A1, B1, 1'b1, 2'd2, 1'b0, 1'b0, 36'd0);
    send(A1, B1, 1'b0, 2'd0, 1'b0, 1'b1, 36'd2567);
    send(A1, B1, 1'b1, 2'd2, 1'b1, 1'b1, 36'd14);
    drain();

    // backpressure with six SUM beats
    fork
      begin
        send({9'd1, 9'd2}, {9'd3, 9'd4}, 1'b0, 2'd0, 1'b0, 1'b1, 36'd11);
        send({9'd10, 9'd0}, {9'd10, 9'd7}, 1'b0, 2'd0, 1'b0, 1'b1, 36'd100);
        send({9'd2, 9'd2}, {9'd2, 9'd2}, 1'b0, 2'd0, 1'b0, 1'b1, 36'd8);
        send({9'd0, 9'd9}, {9'd0, 9'd9}, 1'b0, 2'd0, 1'b0, 1'b1, 36'd81);
        send({9'd5, 9'd6}, {9'd7, 9'd8}, 1'b0, 2'd0, 1'b0, 1'b1, 36'd83);
        send({9'd100, 9'd1}, {9'd3, 9'd1}, 1'b0, 2'd0, 1'b0, 1'b1, 36'd301);
      end
      begin
        n = 0;
        out_ready = 1'b0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("bp_valid", 64'(out_valid), 64'd1);
        held = out_y;
        repeat (5) begin
          @(negedge clk);
          check("bp_hold", 64'(out_y), 64'(held));
          check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // reset in the middle of an ACC burst
    send(A1, B1, 1'b1, 2'd2, 1'b0, 1'b0, 36'd0);
    send(A1, B1, 1'b1, 2'd2, 1'b0, 1'b0, 36'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_y", 64'(out_y), 64'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_output", 64'(seen), 64'd0);
    @(posedge clk); #1;
    send(A1, B1, 1'b1, 2'd2, 1'b1, 1'b1, 36'd7);
    drain();

    // mixed modes back to back
    send(A1, B1, 1'b1, 2'd0, 1'b0, 1'b1, 36'd7);
    send(A1, B1, 1'b1, 2'd1, 1'b0, 1'b1, 36'hFFFEC000C);
    send(A1, B1, 1'b1, 2'd2, 1'b1, 1'b1, 36'd7);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mixed_first", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("mixed_second", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("mixed_third", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("mixed_after", 64'(out_valid), 64'd0);
    drain();

    check("result_count", 64'(nres), 64'(npush));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
